// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants and types for the data-memory stage:
//                MMIO address map, STATUS bit positions, default TX FIFO
//                depth and the address decoder used by the top level.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

   // MMIO page
   localparam logic [15:0] ADDR_GPIO_OUT = 16'hFF00;
   localparam logic [15:0] ADDR_GPIO_IN  = 16'hFF01;
   localparam logic [15:0] ADDR_TX       = 16'hFF02;
   localparam logic [15:0] ADDR_TIMER    = 16'hFF03;
   localparam logic [15:0] ADDR_STATUS   = 16'hFF04;
   localparam logic [15:0] ADDR_TCMP     = 16'hFF05;

   // STATUS register bit positions
   localparam int ST_FULL   = 0;
   localparam int ST_EMPTY  = 1;
   localparam int ST_TMATCH = 2;
   localparam int ST_TXOVF  = 3;

   localparam int TXF_DEPTH_DEF = 4;

   // Decoded target of a data-port access
   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_GPO,
      SEL_GPI,
      SEL_TX,
      SEL_TMR,
      SEL_STAT,
      SEL_TCMP
   } sel_e;

   // RAM is partially decoded: any address whose bits above the RAM width are
   // all zero hits the array; everything else is matched against the MMIO page.
   function automatic sel_e decode_addr(input logic [15:0] addr,
                                        input int unsigned ram_aw);
      sel_e sel;
      sel = SEL_NONE;
      if ((addr >> ram_aw) == 16'h0000) begin
         sel = SEL_RAM;
      end else begin
         case (addr)
            ADDR_GPIO_OUT: sel = SEL_GPO;
            ADDR_GPIO_IN:  sel = SEL_GPI;
            ADDR_TX:       sel = SEL_TX;
            ADDR_TIMER:    sel = SEL_TMR;
            ADDR_STATUS:   sel = SEL_STAT;
            ADDR_TCMP:     sel = SEL_TCMP;
            default:       sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tx_fifo
//  Description : Synchronous FIFO with push/pop, full/empty and occupancy
//                count. A push while full is still accepted when a pop
//                happens in the same cycle; otherwise it is dropped and
//                flagged on push_drop_o. DEPTH must be a power of two (>=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push_i,
   input  logic [WIDTH-1:0]        wdata_i,
   input  logic                    pop_i,
   output logic [WIDTH-1:0]        rdata_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic                    push_drop_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q,  count_d;
   logic             w_push_fire;
   logic             w_pop_fire;

   assign full_o      = (count_q == CNT_FULL);
   assign empty_o     = (count_q == '0);
   assign w_pop_fire  = pop_i & ~empty_o;
   assign w_push_fire = push_i & (~full_o | w_pop_fire);
   assign push_drop_o = push_i & ~w_push_fire;
   // Head is forced to zero when empty so the output is defined after reset
   assign rdata_o     = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o     = count_q;

   // Next-state pointers and occupancy
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_push_fire, w_pop_fire})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since the head is masked when empty
   always_ff @(posedge clk) begin
      if (!rst && w_push_fire) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/data_memory_unit.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_unit
//  Description : Data-memory stage for a single-cycle core. Word-addressed
//                RAM plus an MMIO page holding GPIO, a byte TX FIFO with a
//                valid/ready drain and a free-running timer with compare.
//                Reads are combinational; writes commit on the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_unit
   import dmem_pkg::*;
#(
   parameter int RAM_AW    = 6,
   parameter int TXF_DEPTH = TXF_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_wdata,
   output logic [15:0] mem_rdata,
   input  logic [15:0] gpio_in,
   output logic [15:0] gpio_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        irq
);

   localparam int RAM_WORDS = 1 << RAM_AW;
   localparam int CW        = $clog2(TXF_DEPTH) + 1;

   logic [15:0]   ram_q [RAM_WORDS];
   logic [15:0]   gpio_out_q, gpio_out_d;
   logic [15:0]   sync1_q, sync2_q;
   logic [15:0]   timer_q, timer_d;
   logic [15:0]   tcmp_q, tcmp_d;
   logic          match_q, match_d;
   logic          ovf_q, ovf_d;

   sel_e          w_sel;
   logic          w_wr_gpo, w_wr_tx, w_wr_tmr, w_wr_stat, w_wr_tcmp, w_wr_ram;
   logic          w_full, w_empty, w_drop, w_pop;
   logic [CW-1:0] w_count;
   logic [15:0]   w_status;

   assign w_sel     = decode_addr(mem_addr, RAM_AW);
   assign w_wr_ram  = mem_wr & (w_sel == SEL_RAM);
   assign w_wr_gpo  = mem_wr & (w_sel == SEL_GPO);
   assign w_wr_tx   = mem_wr & (w_sel == SEL_TX);
   assign w_wr_tmr  = mem_wr & (w_sel == SEL_TMR);
   assign w_wr_stat = mem_wr & (w_sel == SEL_STAT);
   assign w_wr_tcmp = mem_wr & (w_sel == SEL_TCMP);

   assign w_pop     = tx_valid & tx_ready;
   assign tx_valid  = ~w_empty;
   assign gpio_out  = gpio_out_q;
   assign irq       = match_q;

   tx_fifo #(
      .DEPTH (TXF_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (w_wr_tx),
      .wdata_i     (mem_wdata[7:0]),
      .pop_i       (w_pop),
      .rdata_o     (tx_data),
      .full_o      (w_full),
      .empty_o     (w_empty),
      .push_drop_o (w_drop),
      .count_o     (w_count)
   );

   // Next-state for MMIO registers, timer and sticky flags (sets beat W1C clears)
   always_comb begin
      gpio_out_d = gpio_out_q;
      tcmp_d     = tcmp_q;
      timer_d    = timer_q + 16'd1;
      match_d    = match_q;
      ovf_d      = ovf_q;
      if (w_wr_gpo)  gpio_out_d = mem_wdata;
      if (w_wr_tcmp) tcmp_d     = mem_wdata;
      if (w_wr_tmr)  timer_d    = mem_wdata;
      if (w_wr_stat && mem_wdata[ST_TMATCH]) match_d = 1'b0;
      if (w_wr_stat && mem_wdata[ST_TXOVF])  ovf_d   = 1'b0;
      if (timer_q == tcmp_q) match_d = 1'b1;
      if (w_drop)            ovf_d   = 1'b1;
   end

   // Register update; reset overrides any write in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         gpio_out_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         timer_q    <= '0;
         tcmp_q     <= '0;
         match_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         gpio_out_q <= gpio_out_d;
         sync1_q    <= gpio_in;
         sync2_q    <= sync1_q;
         timer_q    <= timer_d;
         tcmp_q     <= tcmp_d;
         match_q    <= match_d;
         ovf_q      <= ovf_d;
      end
   end

   // RAM write port; contents are intentionally not cleared by reset
   always_ff @(posedge clk) begin
      if (!rst && w_wr_ram) begin
         ram_q[mem_addr[RAM_AW-1:0]] <= mem_wdata;
      end
   end

   // Assemble the STATUS view
   always_comb begin
      w_status            = '0;
      w_status[ST_FULL]   = w_full;
      w_status[ST_EMPTY]  = w_empty;
      w_status[ST_TMATCH] = match_q;
      w_status[ST_TXOVF]  = ovf_q;
   end

   // Combinational read mux, zero when not reading or unmapped
   always_comb begin
      mem_rdata = '0;
      if (mem_rd) begin
         case (w_sel)
            SEL_RAM:  mem_rdata = ram_q[mem_addr[RAM_AW-1:0]];
            SEL_GPO:  mem_rdata = gpio_out_q;
            SEL_GPI:  mem_rdata = sync2_q;
            SEL_TX:   mem_rdata = 16'(w_count);
            SEL_TMR:  mem_rdata = timer_q;
            SEL_STAT: mem_rdata = w_status;
            SEL_TCMP: mem_rdata = tcmp_q;
            default:  mem_rdata = '0;
         endcase
      end
   end

endmodule
`default_nettype wire
